decoder_3to8_pending: RTL and testbench

- Registered 3-to-8 decoder with a valid/ready input handshake. It is the return path for the 8:3 priority encoder.
- Each accepted 3-bit code produces a one-hot pulse of configurable width on o.
- It also sets a sticky per-line pending bit, which the consumer clears with ack.
- A sticky overflow flag reports a code that arrives while its line is still pending.

---
 rtl/decoder_3to8_pending_if.sv | 25 ++
 rtl/decoder_3to8_pending.sv | 82 ++++++++
 tb/tb_decoder_3to8_pending.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_pending_if.sv
// Handshake and status bundle between a code sender and decoder_3to8_pending.
//   in_valid/code : sender offers a 3-bit line index
//   in_ready      : decoder can accept this cycle
//   ack/ovf_clr   : consumer clears pending bits / overflow flag
//   o/pend/ovf    : one-hot pulse, sticky pending bits, sticky overflow
interface decoder_3to8_pending_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] code;
   logic [7:0] ack;
   logic       ovf_clr;
   logic [7:0] o;
   logic [7:0] pend;
   logic       ovf;

   modport master (
      output in_valid, code, ack, ovf_clr,
      input  in_ready, o, pend, ovf
   );

   modport slave (
      input  in_valid, code, ack, ovf_clr,
      output in_ready, o, pend, ovf
   );
endinterface

// File: rtl/decoder_3to8_pending.sv
// Registered 3-to-8 decoder with valid/ready input, PULSE_W-cycle one-hot
// output pulse, sticky per-line pending bits and a sticky overflow flag.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : slave side of decoder_3to8_pending_if
//          (in_valid, in_ready, code, ack, ovf_clr, o, pend, ovf)
module decoder_3to8_pending #(
   parameter int unsigned PULSE_W = 1
) (
   input logic                    clk,
   input logic                    rst,
   decoder_3to8_pending_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(PULSE_W) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      PULSE = 1'b1
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic [7:0]         set_mask;
   logic               ovf_set;

   // Accept only in IDLE; the code is sampled at the accept edge alone.
   always_comb begin
      accept   = (state == IDLE) && bus.in_valid;
      set_mask = accept ? (8'(1) << bus.code) : 8'h00;
      // A same-cycle ack on the line counts as serviced, so no overflow.
      ovf_set  = accept && bus.pend[bus.code] && !bus.ack[bus.code];
   end

   assign bus.in_ready = (state == IDLE);

   // Pulse FSM, pending bits and overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bus.o    <= 8'h00;
         bus.pend <= 8'h00;
         bus.ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  bus.o <= set_mask;
                  cnt   <= CNT_W'(PULSE_W - 1);
                  state <= PULSE;
               end
            end
            PULSE: begin
               // Dropping to IDLE forces one o=0 cycle between pulses.
               if (cnt == '0) begin
                  bus.o <= 8'h00;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               bus.o <= 8'h00;
               state <= IDLE;
            end
         endcase

         // Set wins over a same-edge ack on the same line.
         bus.pend <= (bus.pend & ~bus.ack) | set_mask;

         // New overflow wins over a same-edge clear.
         if (ovf_set) begin
            bus.ovf <= 1'b1;
         end else if (bus.ovf_clr) begin
            bus.ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decoder_3to8_pending.sv
// Bench for decoder_3to8_pending: four instances (PULSE_W = 1..4) share one
// stimulus stream. Directed table rows check one chosen instance against
// hand-derived values; every cycle all instances are also checked against a
// remaining-cycles reference model.
module tb_decoder_3to8_pending;

   localparam int unsigned N_INST = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [2:0] code;
   logic [7:0] ack;
   logic       ovf_clr;

   logic [N_INST-1:0][7:0] o_a;
   logic [N_INST-1:0][7:0] pend_a;
   logic [N_INST-1:0]      ovf_a;
   logic [N_INST-1:0]      rdy_a;

   int n_checks;
   int n_fail;

   for (genvar k = 0; k < N_INST; k++) begin : g_dut
      decoder_3to8_pending_if bus ();
      assign bus.in_valid = in_valid;
      assign bus.code     = code;
      assign bus.ack      = ack;
      assign bus.ovf_clr  = ovf_clr;
      assign o_a[k]       = bus.o;
      assign pend_a[k]    = bus.pend;
      assign ovf_a[k]     = bus.ovf;
      assign rdy_a[k]     = bus.in_ready;

      decoder_3to8_pending #(.PULSE_W(k + 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus.slave)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cycles of pulse still to show, plus plain bit arrays.
   int       m_left [N_INST];
   int       m_code [N_INST];
   bit [7:0] m_pend [N_INST];
   bit       m_ovf  [N_INST];

   task automatic model_step();
      for (int k = 0; k < N_INST; k++) begin
         if (rst) begin
            m_left[k] = 0;
            m_pend[k] = 8'h00;
            m_ovf[k]  = 1'b0;
         end else begin
            bit acc;
            bit ov;
            acc = (m_left[k] == 0) && in_valid;
            ov  = acc && m_pend[k][code] && !ack[code];
            for (int i = 0; i < 8; i++) begin
               m_pend[k][i] = (m_pend[k][i] && !ack[i]) || (acc && (i == int'(code)));
            end
            if (ov) m_ovf[k] = 1'b1;
            else if (ovf_clr) m_ovf[k] = 1'b0;
            if (acc) begin
               m_left[k] = k + 1;
               m_code[k] = int'(code);
            end else if (m_left[k] > 0) begin
               m_left[k] = m_left[k] - 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input int inst,
                        input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got %h expected %h", name, inst, got, exp);
      end
   endtask

   // One clock edge: advance model, then compare all instances after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < N_INST; k++) begin
         logic [7:0] exp_o;
         exp_o = (m_left[k] > 0) ? (8'(1) << m_code[k]) : 8'h00;
         check("model_o",     k, o_a[k],            exp_o);
         check("model_ready", k, 8'(rdy_a[k]),      8'(m_left[k] == 0));
         check("model_pend",  k, pend_a[k],         m_pend[k]);
         check("model_ovf",   k, 8'(ovf_a[k]),      8'(m_ovf[k]));
      end
   endtask

   typedef struct {
      bit         rst;
      bit         vld;
      bit [2:0]   code;
      bit [7:0]   ack;
      bit         clr;
      int         inst;
      bit [7:0]   o;
      bit         rdy;
      bit [7:0]   pend;
      bit         ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit r, input bit v, input bit [2:0] c,
                               input bit [7:0] a, input bit cl, input int inst,
                               input bit [7:0] eo, input bit er,
                               input bit [7:0] ep, input bit ev);
      vec_t t;
      t.rst = r;  t.vld = v;  t.code = c;  t.ack = a;  t.clr = cl;
      t.inst = inst;
      t.o = eo;   t.rdy = er; t.pend = ep; t.ovf = ev;
      vecs.push_back(t);
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int k = 0; k < N_INST; k++) begin
         m_left[k] = 0; m_code[k] = 0; m_pend[k] = 8'h00; m_ovf[k] = 1'b0;
      end
      rst = 1'b1; in_valid = 1'b0; code = 3'd0; ack = 8'h00; ovf_clr = 1'b0;

      //   rst vld code ack  clr inst   o     rdy pend  ovf
      // 1: PULSE_W=1 single code 5
      add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0);
      add(0, 1, 5, 8'h00, 0, 0, 8'h20, 0, 8'h20, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h20, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h20, 0);
      // 2: PULSE_W=3, valid held, code 0 then 7
      add(1, 0, 0, 8'h00, 0, 2, 8'h00, 1, 8'h00, 0);
      add(0, 1, 0, 8'h00, 0, 2, 8'h01, 0, 8'h01, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h01, 0, 8'h01, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h01, 0, 8'h01, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h00, 1, 8'h01, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h80, 0, 8'h81, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h80, 0, 8'h81, 0);
      add(0, 1, 7, 8'h00, 0, 2, 8'h80, 0, 8'h81, 0);
      add(0, 0, 0, 8'h00, 0, 2, 8'h00, 1, 8'h81, 0);
      // 3: overflow, then same with servicing ack
      add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 1);
      add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 0);
      add(0, 1, 2, 8'h04, 0, 0, 8'h04, 0, 8'h04, 0);
      // 4: clearing pend and ovf
      add(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 0);
      add(0, 1, 5, 8'h00, 0, 0, 8'h20, 0, 8'h24, 0);
      add(0, 0, 0, 8'hFF, 0, 0, 8'h00, 1, 8'h00, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 0);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 0);
      add(0, 1, 2, 8'h00, 0, 0, 8'h04, 0, 8'h04, 1);
      add(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 1);
      add(0, 1, 2, 8'h00, 1, 0, 8'h04, 0, 8'h04, 1);
      add(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h04, 0);
      // 5: PULSE_W=4, reset on 2nd pulse cycle with valid code 3 present
      add(1, 0, 0, 8'h00, 0, 3, 8'h00, 1, 8'h00, 0);
      add(0, 1, 1, 8'h00, 0, 3, 8'h02, 0, 8'h02, 0);
      add(0, 0, 0, 8'h00, 0, 3, 8'h02, 0, 8'h02, 0);
      add(1, 1, 3, 8'h00, 0, 3, 8'h00, 1, 8'h00, 0);
      add(1, 1, 3, 8'h00, 0, 3, 8'h00, 1, 8'h00, 0);
      add(0, 0, 0, 8'h00, 0, 3, 8'h00, 1, 8'h00, 0);
      // 6: PULSE_W=2 backpressure
      add(1, 0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h00, 0);
      add(0, 1, 1, 8'h00, 0, 1, 8'h02, 0, 8'h02, 0);
      add(0, 1, 6, 8'h00, 0, 1, 8'h02, 0, 8'h02, 0);
      add(0, 1, 6, 8'h00, 0, 1, 8'h00, 1, 8'h02, 0);
      add(0, 1, 6, 8'h00, 0, 1, 8'h40, 0, 8'h42, 0);
      add(0, 0, 0, 8'h00, 0, 1, 8'h40, 0, 8'h42, 0);
      add(0, 0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h42, 0);

      foreach (vecs[i]) begin
         vec_t t;
         t = vecs[i];
         rst      = t.rst;
         in_valid = t.vld;
         code     = t.code;
         ack      = t.ack;
         ovf_clr  = t.clr;
         tick();
         check($sformatf("vec%0d_o", i),     t.inst, o_a[t.inst],           t.o);
         check($sformatf("vec%0d_ready", i), t.inst, 8'(rdy_a[t.inst]),     8'(t.rdy));
         check($sformatf("vec%0d_pend", i),  t.inst, pend_a[t.inst],        t.pend);
         check($sformatf("vec%0d_ovf", i),   t.inst, 8'(ovf_a[t.inst]),     8'(t.ovf));
      end

      // Randomised traffic checked against the model on every edge.
      for (int n = 0; n < 2000; n++) begin
         rst      = ($urandom_range(0, 63) == 0);
         in_valid = ($urandom_range(0, 9) < 6);
         code     = 3'($urandom);
         ack      = 8'($urandom & $urandom & $urandom);
         ovf_clr  = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
